// File: rtl/pulse_meter.sv
// Measures the high width of pulse_in in clocks and holds the result until it is acked.
// Build option PULSE_METER_SAT_EN: the counter saturates rather than wraps.
module pulse_meter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pulse_in,
    input  logic [W-1:0] limit,
    input  logic         ack,
    output logic [W-1:0] width,
    output logic         valid,
    output logic         long_pulse,
    output logic         ovf,
    output logic         missed,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;

    state_t       state_q, state_d;
    logic         p_q, p_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] width_q, width_d;
    logic         valid_q, valid_d;
    logic         long_q, long_d;
    logic         ovf_q, ovf_d;
    logic         missed_q, missed_d;
    logic         busy_o_d;

    logic rise;
    logic start;
    logic at_max;

    assign rise   = pulse_in & ~p_q;
    assign at_max = (cnt_q == CNT_MAX);
    // A new measurement may begin from IDLE, or from DONE when the ack coincides with the rise.
    assign start  = rise & ((state_q == S_IDLE) | ((state_q == S_DONE) & ack));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rise) state_d = S_MEASURE;
            S_MEASURE: if (!pulse_in) state_d = S_DONE;
            S_DONE:    if (ack) state_d = rise ? S_MEASURE : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o_d = (state_q == S_MEASURE);
    end

    always_comb begin
        p_d      = pulse_in;
        cnt_d    = cnt_q;
        width_d  = width_q;
        valid_d  = valid_q;
        long_d   = long_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;

        case (state_q)
            S_MEASURE: begin
                if (pulse_in) begin
                    if (at_max) begin
                        ovf_d = 1'b1;
                    end
`ifdef PULSE_METER_SAT_EN
                    if (!at_max) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = cnt_q + 1'b1;
`endif
                end else begin
                    width_d = cnt_q;
                    long_d  = (cnt_q >= limit);
                    valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (ack) begin
                    valid_d  = 1'b0;
                    missed_d = 1'b0;
                end else if (rise) begin
                    missed_d = 1'b1;
                end
            end
            S_IDLE: begin
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase

        if (start) begin
            cnt_d = W'(1);
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_q      <= 1'b1;
            cnt_q    <= '0;
            width_q  <= '0;
            valid_q  <= 1'b0;
            long_q   <= 1'b0;
            ovf_q    <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            long_q   <= long_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
        end
    end

    assign width      = width_q;
    assign valid      = valid_q;
    assign long_pulse = long_q;
    assign ovf        = ovf_q;
    assign missed     = missed_q;
    assign busy       = busy_o_d;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed scenarios plus random pulse trains, checked every cycle against a run-length model.
module tb_pulse_meter;

    localparam int W = 6;

    logic         clk;
    logic         reset;
    logic         pulse_in;
    logic [W-1:0] limit;
    logic         ack;
    logic [W-1:0] width;
    logic         valid;
    logic         long_pulse;
    logic         ovf;
    logic         missed;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain integer run length of the current high pulse.
    bit m_prev  = 1'b1;
    bit m_meas  = 1'b0;
    int m_run   = 0;
    bit m_valid = 1'b0;
    int m_w     = 0;
    bit m_lg    = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_mis   = 1'b0;

    pulse_meter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .limit      (limit),
        .ack        (ack),
        .width      (width),
        .valid      (valid),
        .long_pulse (long_pulse),
        .ovf        (ovf),
        .missed     (missed),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_start();
        m_meas = 1'b1;
        m_run  = 1;
        m_ovf  = 1'b0;
    endtask

    task automatic model_update(input bit pi, input int lim, input bit ak, input bit rst);
        bit r;
        if (!rst) begin
            m_prev = 1'b1; m_meas = 1'b0; m_run = 0; m_valid = 1'b0;
            m_w = 0; m_lg = 1'b0; m_ovf = 1'b0; m_mis = 1'b0;
        end else begin
            r = pi && !m_prev;
            if (m_meas) begin
                if (pi) begin
                    m_run++;
                    if (m_run > 63) m_ovf = 1'b1;
                end else begin
                    m_meas  = 1'b0;
                    m_valid = 1'b1;
`ifdef PULSE_METER_SAT_EN
                    m_w = (m_run > 63) ? 63 : m_run;
`else
                    m_w = m_run % 64;
`endif
                    m_lg = (m_w >= lim);
                end
            end else if (m_valid) begin
                if (ak) begin
                    m_valid = 1'b0;
                    m_mis   = 1'b0;
                    if (r) model_start();
                end else if (r) begin
                    m_mis = 1'b1;
                end
            end else if (r) begin
                model_start();
            end
            m_prev = pi;
        end
    endtask

    task automatic compare_all();
        check("valid", int'(valid), int'(m_valid));
        check("busy", int'(busy), int'(m_meas));
        check("missed", int'(missed), int'(m_mis));
        check("ovf", int'(ovf), int'(m_ovf));
        check("width", int'(width), m_w);
        check("long_pulse", int'(long_pulse), int'(m_lg));
    endtask

    task automatic step(input bit pi, input int lim, input bit ak, input bit rst);
        pulse_in = pi;
        limit    = W'(lim);
        ack      = ak;
        reset    = rst;
        @(posedge clk);
        model_update(pi, lim, ak, rst);
        #1;
        compare_all();
    endtask

    task automatic run_pulse(input int n, input int lim);
        for (int i = 0; i < n; i++) step(1'b1, lim, 1'b0, 1'b1);
        step(1'b0, lim, 1'b0, 1'b1);
    endtask

    initial begin
        pulse_in = 1'b1;
        limit    = '0;
        ack      = 1'b0;
        reset    = 1'b0;
        #2;

        // Reset with the pulse already high: no measurement until a real rise.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_valid", int'(valid), 0);
        check("rst_width", int'(width), 0);
        for (int i = 0; i < 3; i++) step(1, 3, 1, 1);
        check("no_meas_busy", int'(busy), 0);
        step(0, 3, 0, 1);

        run_pulse(5, 4);
        check("p5_width", int'(width), 5);
        check("p5_long", int'(long_pulse), 1);
        check("p5_valid", int'(valid), 1);
        for (int i = 0; i < 3; i++) step(0, 4, 0, 1);
        step(0, 4, 1, 1);
        check("p5_ack_valid", int'(valid), 0);
        run_pulse(5, 6);
        check("p5_short", int'(long_pulse), 0);
        step(0, 6, 1, 1);

        run_pulse(70, 10);
`ifdef PULSE_METER_SAT_EN
        check("p70_width", int'(width), 63);
`else
        check("p70_width", int'(width), 6);
`endif
        check("p70_ovf", int'(ovf), 1);
        step(0, 10, 1, 1);
        run_pulse(2, 10);
        check("p2_ovf", int'(ovf), 0);
        check("p2_width", int'(width), 2);

        // Still pending: a new pulse is dropped and flagged.
        run_pulse(3, 10);
        check("miss_flag", int'(missed), 1);
        check("miss_width", int'(width), 2);
        step(0, 10, 1, 1);
        check("miss_clear", int'(missed), 0);
        check("miss_idle", int'(busy), 0);

        run_pulse(6, 1);
        step(1, 1, 1, 1);
        check("coinc_valid", int'(valid), 0);
        check("coinc_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        check("coinc_width", int'(width), 4);
        step(0, 1, 1, 1);

        step(1, 5, 0, 1);
        step(1, 5, 0, 1);
        step(1, 5, 0, 0);
        check("abort_busy", int'(busy), 0);
        check("abort_width", int'(width), 0);
        for (int i = 0; i < 7; i++) step(1, 5, 0, 1);
        check("abort_ignored", int'(busy), 0);
        check("abort_novalid", int'(valid), 0);
        step(0, 5, 0, 1);

        for (int k = 0; k < 200; k++) begin
            int hi;
            int lo;
            hi = (k % 10 == 0) ? int'($urandom_range(60, 140)) : int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 6));
            for (int c = 0; c < hi + lo; c++) begin
                step(c < hi, int'($urandom_range(0, 63)), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 299) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
